// File: rtl/i2c_pwm_pkg.sv
// Shared constants for the I2C-programmed PWM controller: FSM encodings,
// register-map offsets and the input glitch-filter helper.
package i2c_pwm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_ADDR      = 4'd1;
    localparam state_t ST_ADDR_ACK  = 4'd2;
    localparam state_t ST_PTR       = 4'd3;
    localparam state_t ST_PTR_ACK   = 4'd4;
    localparam state_t ST_WDATA     = 4'd5;
    localparam state_t ST_WDATA_ACK = 4'd6;
    localparam state_t ST_RDATA     = 4'd7;
    localparam state_t ST_RDATA_ACK = 4'd8;

    localparam int FILT_DEPTH = 3;

    function automatic int reg_en(input int num_ch);
        return num_ch;
    endfunction

    function automatic int reg_presc(input int num_ch);
        return num_ch + 1;
    endfunction

    // Majority vote over the sample history; rejects single-sample glitches.
    function automatic logic majority(input logic [FILT_DEPTH-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < FILT_DEPTH; i++) begin
            if (v[i]) ones++;
        end
        return ones > (FILT_DEPTH / 2);
    endfunction

endpackage

// File: rtl/i2c_pwm_multi_pwm_channel.sv
// One PWM channel: duty shadow reloaded at the period wrap and a registered
// compare against the shared period counter.
module pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic                 en,
    input  logic [PWM_WIDTH-1:0] cnt,
    input  logic                 wrap,
    output logic                 pwm
);
    logic [PWM_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pwm_q, pwm_d;

    always_comb begin
        shadow_d = wrap ? duty : shadow_q;
        pwm_d    = en & (cnt < shadow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/i2c_pwm_multi.sv
// I2C slave with pointer-based register map driving NUM_CH PWM channels from
// a shared prescaled timebase. SCL/SDA are oversampled on clk.
module i2c_pwm_multi
    import i2c_pwm_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR  = 7'h2A,
    parameter int         NUM_CH    = 4,
    parameter int         PWM_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam int NUM_REGS  = NUM_CH + 2;
    localparam int PTR_W     = $clog2(NUM_REGS);
    localparam int REG_EN    = reg_en(NUM_CH);
    localparam int REG_PRESC = reg_presc(NUM_CH);

    logic [1:0]            scl_s_q, scl_s_d, sda_s_q, sda_s_d;
    logic [FILT_DEPTH-1:0] scl_h_q, scl_h_d, sda_h_q, sda_h_d;
    logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic                  scl_p_q, scl_p_d, sda_p_q, sda_p_d;
    logic                  scl_rise, scl_fall, start_ev, stop_ev;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic [7:0]       byte_in;

    logic [7:0]        duty_q [NUM_CH];
    logic [7:0]        duty_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d;
    logic [7:0]        presc_q, presc_d;
    logic [7:0]        regs [NUM_REGS];

    logic [7:0]           presc_cnt_q, presc_cnt_d, presc_act_q, presc_act_d;
    logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick, wrap;

    always_comb begin
        scl_s_d = {scl_s_q[0], scl_i};
        sda_s_d = {sda_s_q[0], sda_i};
        scl_h_d = {scl_h_q[FILT_DEPTH-2:0], scl_s_q[1]};
        sda_h_d = {sda_h_q[FILT_DEPTH-2:0], sda_s_q[1]};
        scl_f_d = majority(scl_h_q);
        sda_f_d = majority(sda_h_q);
        scl_p_d = scl_f_q;
        sda_p_d = sda_f_q;
    end

    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start_ev = scl_f_q & sda_p_q & ~sda_f_q;
    assign stop_ev  = scl_f_q & ~sda_p_q & sda_f_q;

    assign byte_in = {shift_q[6:0], sda_f_q};
    assign ptr_inc = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) regs[i] = duty_q[i];
        regs[REG_EN]    = 8'(en_q);
        regs[REG_PRESC] = presc_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        duty_d    = duty_q;
        en_d      = en_q;
        presc_d   = presc_q;
        if (start_ev) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd7;
            sda_oe_d  = 1'b0;
        end else if (stop_ev) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
                    shift_d = byte_in;
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        bit_cnt_d = 3'd1;
                        if (state_q == ST_ADDR) begin
                            rw_d    = byte_in[0];
                            state_d = (byte_in[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_IDLE;
                        end else if (state_q == ST_PTR) begin
                            ptr_d   = (byte_in >= 8'(NUM_REGS)) ? '0 : byte_in[PTR_W-1:0];
                            state_d = ST_PTR_ACK;
                        end else begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (ptr_q == PTR_W'(i)) duty_d[i] = byte_in;
                            end
                            if (ptr_q == PTR_W'(REG_EN)) en_d = byte_in[NUM_CH-1:0];
                            if (ptr_q == PTR_W'(REG_PRESC)) presc_d = byte_in;
                            ptr_d   = ptr_inc;
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                // bit_cnt = 1 marks the fall that starts the ACK slot, 0 the fall that ends it.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = 3'd7;
                        sda_oe_d  = 1'b0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d  = ST_RDATA;
                            shift_d  = regs[ptr_q];
                            sda_oe_d = ~regs[ptr_q][7];
                        end else begin
                            state_d = (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                        end
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RDATA_ACK;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f_q) begin
                            ptr_d     = ptr_inc;
                            shift_d   = regs[ptr_inc];
                            bit_cnt_d = 3'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (scl_fall && bit_cnt_q != 3'd0) begin
                        state_d   = ST_RDATA;
                        sda_oe_d  = ~shift_q[7];
                        bit_cnt_d = 3'd7;
                    end
                end
                default: ;
            endcase
        end
    end

    // The active prescale value is only swapped at a tick so a shorter PRESC never strands the counter.
    always_comb begin
        tick        = (presc_cnt_q == presc_act_q);
        wrap        = tick && (cnt_q == '1);
        presc_cnt_d = tick ? 8'd0 : presc_cnt_q + 8'd1;
        presc_act_d = tick ? presc_q : presc_act_q;
        cnt_d       = tick ? cnt_q + PWM_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s_q     <= '1;
            sda_s_q     <= '1;
            scl_h_q     <= '1;
            sda_h_q     <= '1;
            scl_f_q     <= 1'b1;
            sda_f_q     <= 1'b1;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
            en_q        <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            presc_act_q <= '0;
            cnt_q       <= '0;
        end else begin
            scl_s_q     <= scl_s_d;
            sda_s_q     <= sda_s_d;
            scl_h_q     <= scl_h_d;
            sda_h_q     <= sda_h_d;
            scl_f_q     <= scl_f_d;
            sda_f_q     <= sda_f_d;
            scl_p_q     <= scl_p_d;
            sda_p_q     <= sda_p_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            duty_q      <= duty_d;
            en_q        <= en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            presc_act_q <= presc_act_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sda_oe = sda_oe_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .duty (duty_q[g][PWM_WIDTH-1:0]),
            .en   (en_q[g]),
            .cnt  (cnt_q),
            .wrap (wrap),
            .pwm  (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_i2c_pwm_multi.sv
// Bench for i2c_pwm_multi: bit-banged I2C master on an open-drain SDA line,
// read data checked against an expected-byte queue, PWM measured by counting.
module tb_i2c_pwm_multi;
    localparam int Q      = 8;
    localparam int NUM_CH = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              scl_m = 1'b1;
    logic              sda_m = 1'b1;
    logic              sda_line;
    logic              sda_oe;
    logic [NUM_CH-1:0] pwm_out;

    int         total   = 0;
    int         bad     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];
    int         run_q[$];
    int         run_len = 0;
    logic       last_oe = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_pwm_multi #(.I2C_ADDR(7'h2A), .NUM_CH(NUM_CH), .PWM_WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_i  (scl_m),
        .sda_i  (sda_line),
        .sda_oe (sda_oe),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    // Length of each completed high pulse on channel 0.
    always @(negedge clk) begin
        if (pwm_out[0]) run_len++;
        else if (run_len != 0) begin
            run_q.push_back(run_len);
            run_len = 0;
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; w(Q);
        scl_m = 1'b1; w(Q);
        sda_m = 1'b0; w(Q);
        scl_m = 1'b0; w(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; w(Q);
        scl_m = 1'b1; w(Q);
        sda_m = 1'b1; w(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; w(Q);
        scl_m = 1'b1; w(2 * Q);
        scl_m = 1'b0; w(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; w(Q);
        scl_m = 1'b1; w(Q);
        b = sda_line;
        last_oe = sda_oe;
        w(Q);
        scl_m = 1'b0; w(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(~ack);
    endtask

    task automatic write_txn(input logic [7:0] ptr, output int acks);
        logic ack;
        acks = 0;
        i2c_start();
        send_byte(8'h54, ack); if (ack) acks++;
        send_byte(ptr, ack);   if (ack) acks++;
        while (wr_q.size() != 0) begin
            send_byte(wr_q.pop_front(), ack);
            if (ack) acks++;
        end
        i2c_stop();
    endtask

    task automatic read_txn(input logic [7:0] ptr, input int n, output int acks);
        logic       ack;
        logic [7:0] d;
        acks = 0;
        i2c_start();
        send_byte(8'h54, ack); if (ack) acks++;
        send_byte(ptr, ack);   if (ack) acks++;
        i2c_start();
        send_byte(8'h55, ack); if (ack) acks++;
        for (int i = 0; i < n; i++) begin
            recv_byte(d, i != n - 1);
            rd_q.push_back(d);
        end
        last_oe = sda_oe;
        i2c_stop();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        w(5);
        total++;
        if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b required 0", sda_oe); end
        total++;
        if (pwm_out !== '0) begin bad++; $display("FAIL reset_pwm: got %b required 0000", pwm_out); end
        rst_n = 1'b1;
        w(20);
        total++;
        if (pwm_out !== '0 || sda_oe !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: got pwm=%b oe=%b required 0000/0", pwm_out, sda_oe);
        end
    endtask

    task automatic test_single_write();
        int acks;
        int hi;
        int nbad;
        wr_q.push_back(8'h01);
        write_txn(8'h04, acks);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL en_write_acks: got %0d required 3", acks); end
        run_q.delete();
        wr_q.push_back(8'h40);
        write_txn(8'h00, acks);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL duty_write_acks: got %0d required 3", acks); end
        w(600);
        total++;
        if (run_q.size() < 2) begin
            bad++; $display("FAIL duty_pulse_count: got %0d required >=2", run_q.size());
        end else begin
            nbad = 0;
            foreach (run_q[i]) if (run_q[i] != 64) nbad++;
            total++;
            if (nbad != 0) begin
                bad++; $display("FAIL duty_pulse_len: got first=%0d bad_pulses=%0d required 64", run_q[0], nbad);
            end
        end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out[0]) hi++;
        end
        total++;
        if (hi !== 64) begin bad++; $display("FAIL duty40_window: got %0d required 64", hi); end
    endtask

    task automatic test_burst();
        int acks;
        int hi [NUM_CH];
        int exp_hi [NUM_CH];
        exp_hi = '{64, 128, 192, 256};
        wr_q.push_back(8'h10); wr_q.push_back(8'h20); wr_q.push_back(8'h30);
        wr_q.push_back(8'h40); wr_q.push_back(8'h0F); wr_q.push_back(8'h03);
        write_txn(8'h00, acks);
        total++;
        if (acks !== 8) begin bad++; $display("FAIL burst_acks: got %0d required 8", acks); end
        w(2100);
        for (int c = 0; c < NUM_CH; c++) hi[c] = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) if (pwm_out[c]) hi[c]++;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            total++;
            if (hi[c] !== exp_hi[c]) begin
                bad++; $display("FAIL burst_ch%0d_high: got %0d required %0d", c, hi[c], exp_hi[c]);
            end
        end
    endtask

    task automatic test_read_wrap();
        int         acks;
        logic [7:0] got;
        logic [7:0] exp;
        exp_q.push_back(8'h03); exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        read_txn(8'h05, 3, acks);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL read_hdr_acks: got %0d required 3", acks); end
        total++;
        if (last_oe !== 1'b0) begin bad++; $display("FAIL read_release_after_nack: got %b required 0", last_oe); end
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = rd_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL read_wrap_byte: got %02h required %02h", got, exp); end
        end
    endtask

    task automatic test_bad_addr();
        int         acks;
        logic       ack;
        logic [7:0] got;
        logic [7:0] exp;
        i2c_start();
        send_byte(8'h56, ack);
        total++;
        if (ack !== 1'b0 || last_oe !== 1'b0) begin
            bad++; $display("FAIL bad_addr_ack: got ack=%b oe=%b required 0/0", ack, last_oe);
        end
        acks = 0;
        send_byte(8'h00, ack); if (ack) acks++;
        send_byte(8'h99, ack); if (ack) acks++;
        i2c_stop();
        total++;
        if (acks !== 0) begin bad++; $display("FAIL bad_addr_followon_acks: got %0d required 0", acks); end
        exp_q.push_back(8'h10);
        read_txn(8'h00, 1, acks);
        exp = exp_q.pop_front();
        got = rd_q.pop_front();
        total++;
        if (got !== exp) begin bad++; $display("FAIL bad_addr_no_write: got %02h required %02h", got, exp); end
    endtask

    task automatic test_out_of_range();
        int         acks;
        logic       ack;
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] partial;
        partial = 8'hAB;
        wr_q.push_back(8'h77);
        write_txn(8'h09, acks);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL oor_acks: got %0d required 3", acks); end
        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h01, ack);
        for (int i = 7; i >= 4; i--) send_bit(partial[i]);
        i2c_stop();
        exp_q.push_back(8'h77); exp_q.push_back(8'h20);
        read_txn(8'h00, 2, acks);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL after_stop_acks: got %0d required 3", acks); end
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = rd_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL oor_readback: got %02h required %02h", got, exp); end
        end
    endtask

    task automatic test_reset_mid();
        int         acks;
        logic [7:0] a;
        logic [7:0] got;
        logic [7:0] exp;
        a = 8'h54;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        sda_m = 1'b1; w(Q);
        scl_m = 1'b1; w(Q / 2);
        total++;
        if (sda_oe !== 1'b1) begin bad++; $display("FAIL mid_ack_driven: got %b required 1", sda_oe); end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (sda_oe !== 1'b0) begin bad++; $display("FAIL async_reset_oe: got %b required 0", sda_oe); end
        total++;
        if (pwm_out !== '0) begin bad++; $display("FAIL async_reset_pwm: got %b required 0000", pwm_out); end
        w(4);
        rst_n = 1'b1;
        w(4);
        scl_m = 1'b0; w(Q);
        i2c_stop();
        for (int i = 0; i < NUM_CH + 2; i++) exp_q.push_back(8'h00);
        read_txn(8'h00, NUM_CH + 2, acks);
        total++;
        if (acks !== 3) begin bad++; $display("FAIL post_reset_acks: got %0d required 3", acks); end
        while (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = rd_q.pop_front();
            total++;
            if (got !== exp) begin bad++; $display("FAIL post_reset_reg: got %02h required %02h", got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst();
        test_read_wrap();
        test_bad_addr();
        test_out_of_range();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
